tmds_encoder: RTL
=================

TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 Parameters: none; the encoding is the fixed DVI 1.0 8b/10b scheme.
REQ-002 clk  in  1  pixel clock (pclk domain); all state on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 data_in  in  8  pixel component (red, green or blue), sampled every clk.
REQ-005 c0  in  1  control bit 0 (hsync on channel 0, else 0), sampled every clk.
REQ-006 c1  in  1  control bit 1 (vsync on channel 0, else 0), sampled every clk.
REQ-007 blank_in  in  1  high = blanking (control period); low = active video.
REQ-008 tmds_out  out  10  encoded symbol, bit 0 transmitted first, to serializer.
REQ-009 blank_out  out  1  blank_in delayed to align with tmds_out.

Function
REQ-010 The block SHALL be a 2-stage pipeline: a symbol for inputs sampled at edge N appears on tmds_out after edge N+2; throughput is 1 symbol/clk with no stalls.
REQ-011 Stage 1 SHALL register q_m[8:0], blank, c0 and c1.
- n1 = popcount(data_in).
- XNOR mode if n1>4, or n1==4 and data_in[0]==0; otherwise XOR mode.
- q_m[0]=d[0]; q_m[i] = q_m[i-1] XNOR/XOR d[i] for i=1..7.
- q_m[8] = 0 in XNOR mode, 1 in XOR mode.
REQ-012 Stage 2 SHALL compute n1q and n0q (ones and zeros of q_m[7:0]) and keep a running disparity cnt, 5-bit two's complement.
REQ-013 Balanced case, taken if cnt==0 or n1q==n0q:
- out[9] = ~q_m[8]; out[8] = q_m[8].
- out[7:0] = q_m[8] ? q_m[7:0] : ~q_m[7:0].
- cnt += q_m[8] ? (n1q-n0q) : (n0q-n1q).
REQ-014 Invert case, taken if (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q):
- out = {1, q_m[8], ~q_m[7:0]}.
- cnt += 2*q_m[8] + (n0q-n1q).
REQ-015 Otherwise:
- out = {0, q_m[8], q_m[7:0]}.
- cnt += (n1q-n0q) - 2*(~q_m[8]).
REQ-016 When stage-2 blank is high, tmds_out SHALL be the control code and cnt SHALL be forced to 0 on that edge.
- {c1,c0}=00 -> 0x354; 01 -> 0x0AB; 10 -> 0x154; 11 -> 0x2AB.
REQ-017 cnt SHALL remain within -10..+10 for any input sequence; it SHALL never wrap; arithmetic SHALL be signed, with no truncation before the final 5-bit result.
REQ-018 A transition from blank to active SHALL start encoding with cnt=0 on the first active symbol.
- Active-to-blank SHALL emit the control code in the same cycle blank reaches stage 2.
- No idle or guard symbols are inserted.
REQ-019 blank_out SHALL equal blank_in delayed by exactly 2 clk.

Reset
REQ-020 While rst_n=0, outputs SHALL hold asynchronously:
- tmds_out=0x354, blank_out=1.
- cnt=0; stage-1 registers hold blank=1, c0=c1=0, q_m=0.
REQ-021 Reset SHALL be asserted asynchronously and take effect without a clock edge.
- After deassertion, the first non-reset tmds_out appears after the 2nd rising edge.
- In-flight pipeline contents at reset are discarded.
REQ-022 No output SHALL be X after reset for any known input.

Verification
REQ-023 Reset, blank_in=1, c1c0=00 -> tmds_out=0x354 every cycle; then c1c0=01,10,11 -> 0x0AB, 0x154, 0x2AB, each 2 clk after its input.
REQ-024 blank_in=0 from cnt=0, data_in=0x00 for 4 cycles:
- tmds_out = 0x100, 0x3FF, 0x100, 0x3FF.
- cnt = -8, +2, -6, +4.
REQ-025 blank_in=0 from cnt=0, data_in=0xFF -> tmds_out=0x200, cnt=-8.
REQ-026 Random 10,000 active pixels vs. a reference model -> bit-exact tmds_out; |cnt|<=10 always; decoding each symbol returns data_in.
REQ-027 Active burst, then blank for 1 cycle, then active:
- cnt = 0 at the first post-blank symbol.
- blank_out aligned with tmds_out.
REQ-028 rst_n pulsed low mid-active-line for less than 1 clk period -> immediate tmds_out=0x354 and blank_out=1; encoding resumes 2 clk after release with cnt=0.

Source files
------------

// File: rtl/tmds_if.sv
// Pixel-side bus of the DVI TMDS channel encoder.
// The master drives one pixel component, the control bits and the blanking flag
// every pixel clock. The slave returns the 10-bit symbol and the aligned blank flag.
interface tmds_if;
   logic [7:0] data_in;
   logic       c0;
   logic       c1;
   logic       blank_in;
   logic [9:0] tmds_out;
   logic       blank_out;

   modport master (
      output data_in, c0, c1, blank_in,
      input  tmds_out, blank_out
   );

   modport slave (
      input  data_in, c0, c1, blank_in,
      output tmds_out, blank_out
   );
endinterface

// File: rtl/tmds_encoder.sv
// DVI 1.0 TMDS 8b/10b channel encoder. It is a two-stage pipeline with one symbol per clock.
// Stage 1 minimises transitions and produces q_m.
// Stage 2 balances DC through a running disparity counter, or emits a control code during blanking.
module tmds_encoder (
   input  logic  clk,
   input  logic  rst_n,
   tmds_if.slave bus
);

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

   // Transition-minimising chain. Bit 8 records which mode was chosen (1 = XOR).
   function automatic logic [8:0] encode_qm(input logic [7:0] d);
      logic [3:0] n1;
      logic       use_xnor;
      logic [8:0] qm;
      n1       = popcount8(d);
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      qm       = '0;
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++)
         qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8]    = ~use_xnor;
      return qm;
   endfunction

   function automatic logic [9:0] ctrl_code(input logic [1:0] c);
      logic [9:0] code;
      case (c)
         2'b00:   code = 10'h354;
         2'b01:   code = 10'h0AB;
         2'b10:   code = 10'h154;
         default: code = 10'h2AB;
      endcase
      return code;
   endfunction

   // The disparity stays within +/-10 by construction. The clamp only guarantees
   // that an unexpected sum can never wrap the 5-bit counter.
   function automatic logic signed [4:0] fit_disparity(input logic signed [6:0] s);
      logic signed [4:0] r;
      if (s > 7'sd10)       r = 5'sd10;
      else if (s < -7'sd10) r = -5'sd10;
      else                  r = s[4:0];
      return r;
   endfunction

   logic [8:0]        q_m_p1;
   logic              blank_p1;
   logic              c0_p1;
   logic              c1_p1;

   logic [9:0]        tmds_p2;
   logic              blank_p2;
   logic signed [4:0] cnt_p2;

   logic [9:0]        sym_nxt;
   logic signed [4:0] cnt_nxt;

   // Stage 1: register q_m with the blanking and control bits that travel alongside it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_m_p1   <= '0;
         blank_p1 <= 1'b1;
         c0_p1    <= 1'b0;
         c1_p1    <= 1'b0;
      end else begin
         q_m_p1   <= encode_qm(bus.data_in);
         blank_p1 <= bus.blank_in;
         c0_p1    <= bus.c0;
         c1_p1    <= bus.c1;
      end
   end

   // Stage 2 decision: choose the symbol polarity from the disparity and update it in 7-bit signed arithmetic.
   always_comb begin
      logic [3:0]        n1q;
      logic signed [6:0] diff;
      logic signed [6:0] cnt_ext;
      logic signed [6:0] two_q8;
      logic              q8;
      logic              balanced;
      logic              invert;
      q8       = q_m_p1[8];
      n1q      = popcount8(q_m_p1[7:0]);
      diff     = signed'({2'b00, n1q, 1'b0}) - 7'sd8;
      cnt_ext  = {{2{cnt_p2[4]}}, cnt_p2};
      two_q8   = q8 ? 7'sd2 : 7'sd0;
      balanced = (cnt_p2 == 5'sd0) || (n1q == 4'd4);
      invert   = ((cnt_p2 > 5'sd0) && (n1q > 4'd4)) ||
                 ((cnt_p2 < 5'sd0) && (n1q < 4'd4));
      sym_nxt  = ctrl_code({c1_p1, c0_p1});
      cnt_nxt  = '0;
      if (!blank_p1) begin
         if (balanced) begin
            sym_nxt = {~q8, q8, (q8 ? q_m_p1[7:0] : ~q_m_p1[7:0])};
            cnt_nxt = fit_disparity(cnt_ext + (q8 ? diff : -diff));
         end else if (invert) begin
            sym_nxt = {1'b1, q8, ~q_m_p1[7:0]};
            cnt_nxt = fit_disparity(cnt_ext + two_q8 - diff);
         end else begin
            sym_nxt = {1'b0, q8, q_m_p1[7:0]};
            cnt_nxt = fit_disparity(cnt_ext + diff - (q8 ? 7'sd0 : 7'sd2));
         end
      end
   end

   // Stage 2: register the symbol, the aligned blank flag and the running disparity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmds_p2  <= 10'h354;
         blank_p2 <= 1'b1;
         cnt_p2   <= '0;
      end else begin
         tmds_p2  <= sym_nxt;
         blank_p2 <= blank_p1;
         cnt_p2   <= cnt_nxt;
      end
   end

   assign bus.tmds_out  = tmds_p2;
   assign bus.blank_out = blank_p2;

endmodule
